pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in a 3-entry scoreboard for the EX, MEM and WB slots, and detects read-after-write hazards against the instruction in ID.
- Drives hold, bubble and flush controls for the PC, if/id, id/ex, ex/mem and mem/wb pipeline registers.
- Arbitrates between data-memory wait, branch redirect and RAW hazard.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source 1 index.
- id_rs1_used  in  1  source 1 is read.
- id_rs2  in  REG_ADDR_W  ID source 2 index.
- id_rs2_used  in  1  source 2 is read.
- id_rd  in  REG_ADDR_W  ID destination.
- id_wen  in  1  ID instruction writes the register file.
- mem_busy  in  1  data memory not ready this cycle.
- flush_req  in  1  single-cycle branch redirect from EX.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold if/id.
- ifid_flush  out  1  clear if/id to NOP.
- idex_stall  out  1  hold id/ex.
- idex_bubble  out  1  load NOP into id/ex.
- exmem_stall  out  1  hold ex/mem.
- memwb_bubble  out  1  load NOP into mem/wb.
- ctrl_state  out  2  current state: 0 RUN, 1 HAZ, 2 MEMW, 3 FLUSH.
- stall_count  out  CNT_W  cycles with pc_stall=1, saturating.

Behaviour:
- Reset (rst=0, async): scoreboard entries invalid, flush_pending=0, state=RUN, stall_count=0; all control outputs 0.
- Scoreboard: entries sb[0..2] = {valid, rd} for the EX, MEM and WB slots.
- The register file writes at the clock edge, so a WB-slot match is still a hazard. No forwarding exists.
- Hazard = id_valid and ((id_rs1_used and rs1≠0 and rs1 matches a valid entry) or (the same for rs2)). Register 0 never hazards.
- Control outputs are combinational from inputs and registered state (zero added latency). Priority per cycle, highest first:
  1. mem_busy=1 (MEMW):
     - pc_stall=ifid_stall=idex_stall=exmem_stall=memwb_bubble=1.
     - Scoreboard frozen.
     - flush_req=1 this cycle sets flush_pending; no flush is output.
  2. flush_req or flush_pending (FLUSH):
     - ifid_flush=1, idex_bubble=1.
     - Scoreboard shifts with an invalid entry inserted at sb[0].
     - flush_pending cleared.
     - Overrides any hazard.
  3. Hazard (HAZ):
     - pc_stall=ifid_stall=1, idex_bubble=1.
     - Scoreboard shifts, inserting invalid.
     - Hazard clears at most 3 cycles after the producer leaves ID.
  4. Otherwise (RUN):
     - All outputs 0.
     - Scoreboard shifts, inserting {id_valid and id_wen and id_rd≠0, id_rd}.
- Shift rule: sb[2] ← sb[1], sb[1] ← sb[0], sb[0] ← new entry. The old sb[2] retires.
- ctrl_state is registered: it shows the branch taken in the previous cycle (RUN after reset).
- stall_count increments on each clock edge where pc_stall=1; it holds at 2^CNT_W−1.
- Reset mid-stall: outputs drop to 0 immediately, scoreboard is cleared, and any pending flush is lost.
- idex_stall and idex_bubble are never both 1. ifid_stall and ifid_flush are never both 1.

Test Plan:
- Back-to-back dependency: write r5, then read rs1=r5 (rs1_used=1).
  - Expect idex_bubble=pc_stall=1 for exactly 3 cycles, then RUN.
  - Expect stall_count=3.
- r0 destination then r0 read:
  - Expect no stall.
  - Expect id_wen=1, rd=0 is not entered (valid=0).
- mem_busy held 4 cycles during a pending hazard:
  - Expect MEMW outputs for 4 cycles with the scoreboard unchanged.
  - Hazard stall resumes afterwards with the original remaining count.
- flush_req with mem_busy=1 in the same cycle, busy lasting 2 cycles:
  - No ifid_flush while busy.
  - ifid_flush=idex_bubble=1 on the first non-busy cycle, exactly once.
- flush_req during an active hazard: flush wins, and the hazard instruction is squashed.
  - Next cycle no stall unless the new ID instruction hazards.
- Counter saturation with CNT_W=4:
  - 20 stalled cycles → stall_count=15.
  - Async rst pulse mid-stall → all outputs 0 and counter 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush sequencer with a 3-slot RAW scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic                  id_rs1_used,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_wen,
   input  logic                  mem_busy,
   input  logic                  flush_req,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_stall,
   output logic                  idex_bubble,
   output logic                  exmem_stall,
   output logic                  memwb_bubble,
   output logic [1:0]            ctrl_state,
   output logic [CNT_W-1:0]      stall_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HAZ   = 2'd1,
      ST_MEMW  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              sb_valid_q, sb_valid_d;
   logic [REG_ADDR_W-1:0]   sb_rd_q [3];
   logic [REG_ADDR_W-1:0]   sb_rd_d [3];
   logic                    flush_pending_q, flush_pending_d;
   logic [CNT_W-1:0]        stall_count_q, stall_count_d;

   logic                    w_hazard;
   logic                    w_shift;
   logic                    w_new_valid;
   logic [REG_ADDR_W-1:0]   w_new_rd;

   // WB-slot matches count too: the register file commits on the same edge.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (sb_valid_q[i]) begin
            if (id_rs1_used && (id_rs1 != '0) && (id_rs1 == sb_rd_q[i]))
               w_hazard = 1'b1;
            if (id_rs2_used && (id_rs2 != '0) && (id_rs2 == sb_rd_q[i]))
               w_hazard = 1'b1;
         end
      end
      w_hazard = w_hazard & id_valid;
   end

   always_comb begin
      pc_stall        = 1'b0;
      ifid_stall      = 1'b0;
      ifid_flush      = 1'b0;
      idex_stall      = 1'b0;
      idex_bubble     = 1'b0;
      exmem_stall     = 1'b0;
      memwb_bubble    = 1'b0;
      state_d         = ST_RUN;
      flush_pending_d = flush_pending_q;
      w_shift         = 1'b1;
      w_new_valid     = 1'b0;
      w_new_rd        = id_rd;

      if (!rst) begin
         w_shift = 1'b0;
      end else if (mem_busy) begin
         pc_stall        = 1'b1;
         ifid_stall      = 1'b1;
         idex_stall      = 1'b1;
         exmem_stall     = 1'b1;
         memwb_bubble    = 1'b1;
         state_d         = ST_MEMW;
         flush_pending_d = flush_pending_q | flush_req;
         w_shift         = 1'b0;
      end else if (flush_req || flush_pending_q) begin
         ifid_flush      = 1'b1;
         idex_bubble     = 1'b1;
         state_d         = ST_FLUSH;
         flush_pending_d = 1'b0;
      end else if (w_hazard) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = ST_HAZ;
      end else begin
         w_new_valid = id_valid & id_wen & (id_rd != '0);
      end

      sb_valid_d = sb_valid_q;
      sb_rd_d    = sb_rd_q;
      if (w_shift) begin
         sb_valid_d = {sb_valid_q[1], sb_valid_q[0], w_new_valid};
         sb_rd_d[2] = sb_rd_q[1];
         sb_rd_d[1] = sb_rd_q[0];
         sb_rd_d[0] = w_new_rd;
      end

      stall_count_d = stall_count_q;
      if (pc_stall && (stall_count_q != {CNT_W{1'b1}}))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_RUN;
         sb_valid_q      <= '0;
         sb_rd_q[0]      <= '0;
         sb_rd_q[1]      <= '0;
         sb_rd_q[2]      <= '0;
         flush_pending_q <= 1'b0;
         stall_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         sb_valid_q      <= sb_valid_d;
         sb_rd_q         <= sb_rd_d;
         flush_pending_q <= flush_pending_d;
         stall_count_q   <= stall_count_d;
      end
   end

   assign ctrl_state  = state_q;
   assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed bench with a cycle-level reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;
   localparam int RW  = 5;
   localparam int CW  = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_rs1_used, id_rs2_used, id_wen, mem_busy, flush_req;
   logic [RW-1:0] id_rs1, id_rs2, id_rd;
   logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
   logic          exmem_stall, memwb_bubble;
   logic [1:0]    ctrl_state;
   logic [CW-1:0] stall_count;

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_wen(id_wen), .mem_busy(mem_busy), .flush_req(flush_req),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_bubble(idex_bubble), .exmem_stall(exmem_stall),
      .memwb_bubble(memwb_bubble), .ctrl_state(ctrl_state), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // model: in-flight destinations, -1 marks an empty slot
   int m_sb [3];
   int m_fp, m_state, m_cnt;
   int x_sb [3];
   int x_fp, x_state, x_cnt;
   int obs_pc, obs_iff, obs_idb, obs_exs;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int in_flight(input int r);
      int hit = 0;
      for (int i = 0; i < 3; i++) if (m_sb[i] == r) hit = 1;
      return hit;
   endfunction

   task automatic model_check();
      int e_pc = 0, e_ifs = 0, e_iff = 0, e_ids = 0, e_idb = 0, e_exs = 0, e_mwb = 0;
      int e_state, e_cnt, ins, shift, haz;
      haz = (id_valid &&
             ((id_rs1_used && id_rs1 != 0 && in_flight(int'(id_rs1))) ||
              (id_rs2_used && id_rs2 != 0 && in_flight(int'(id_rs2))))) ? 1 : 0;
      x_sb = m_sb; x_fp = m_fp; shift = 1; ins = -1;
      if (!rst) begin
         e_state = 0; e_cnt = 0;
         x_sb = '{-1, -1, -1}; x_fp = 0; x_state = 0; x_cnt = 0; shift = 0;
      end else begin
         e_state = m_state; e_cnt = m_cnt;
         if (mem_busy) begin
            e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1; e_mwb = 1;
            x_state = 2; shift = 0;
            if (flush_req) x_fp = 1;
         end else if (flush_req || m_fp != 0) begin
            e_iff = 1; e_idb = 1; x_state = 3; x_fp = 0;
         end else if (haz != 0) begin
            e_pc = 1; e_ifs = 1; e_idb = 1; x_state = 1;
         end else begin
            x_state = 0;
            if (id_valid && id_wen && id_rd != 0) ins = int'(id_rd);
         end
         if (shift != 0) x_sb = '{ins, m_sb[0], m_sb[1]};
         x_cnt = (e_pc != 0 && m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
      end
      chk("pc_stall",     int'(pc_stall),     e_pc);
      chk("ifid_stall",   int'(ifid_stall),   e_ifs);
      chk("ifid_flush",   int'(ifid_flush),   e_iff);
      chk("idex_stall",   int'(idex_stall),   e_ids);
      chk("idex_bubble",  int'(idex_bubble),  e_idb);
      chk("exmem_stall",  int'(exmem_stall),  e_exs);
      chk("memwb_bubble", int'(memwb_bubble), e_mwb);
      chk("ctrl_state",   int'(ctrl_state),   e_state);
      chk("stall_count",  int'(stall_count),  e_cnt);
      obs_pc = int'(pc_stall); obs_iff = int'(ifid_flush);
      obs_idb = int'(idex_bubble); obs_exs = int'(exmem_stall);
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      @(posedge clk);
      m_sb = x_sb; m_fp = x_fp; m_state = x_state; m_cnt = x_cnt;
      #2;
   endtask

   task automatic set_id(input int v, input int r1, input int u1, input int r2,
                         input int u2, input int rd, input int wen);
      id_valid = v[0]; id_rs1 = r1[RW-1:0]; id_rs1_used = u1[0];
      id_rs2 = r2[RW-1:0]; id_rs2_used = u2[0]; id_rd = rd[RW-1:0]; id_wen = wen[0];
   endtask

   initial begin
      int cnt_a, cnt_b;
      m_sb = '{-1, -1, -1}; m_fp = 0; m_state = 0; m_cnt = 0;
      x_sb = m_sb; x_fp = 0; x_state = 0; x_cnt = 0;
      rst = 1'b0; mem_busy = 1'b0; flush_req = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);

      // reset
      repeat (2) cycle();
      rst = 1'b1;
      chk("reset_state", int'(ctrl_state), 0);
      chk("reset_count", int'(stall_count), 0);

      // back-to-back dependency on r5
      set_id(1, 0, 0, 0, 0, 5, 1); cycle();
      set_id(1, 5, 1, 0, 0, 0, 0);
      cnt_a = 0;
      repeat (5) begin cycle(); cnt_a += obs_pc; end
      chk("raw_stall_cycles", cnt_a, 3);
      chk("raw_then_run", obs_pc, 0);
      chk("raw_stall_count", int'(stall_count), 3);

      // r0 is never a hazard
      set_id(1, 0, 0, 0, 0, 0, 1); cycle();
      set_id(1, 0, 1, 0, 1, 0, 0); cycle();
      chk("r0_no_stall", obs_pc, 0);

      // mem_busy freezes a pending hazard
      set_id(0, 0, 0, 0, 0, 0, 0); cycle();
      set_id(1, 0, 0, 0, 0, 7, 1); cycle();
      set_id(1, 0, 0, 7, 1, 0, 0); cycle();
      cnt_a = obs_idb; cnt_b = 0;
      mem_busy = 1'b1;
      repeat (4) begin cycle(); cnt_a += obs_idb; cnt_b += obs_exs; end
      mem_busy = 1'b0;
      repeat (4) begin cycle(); cnt_a += obs_idb; end
      chk("busy_cycles", cnt_b, 4);
      chk("haz_across_busy", cnt_a, 3);

      // flush deferred by mem_busy
      set_id(0, 0, 0, 0, 0, 0, 0);
      mem_busy = 1'b1; flush_req = 1'b1; cycle(); cnt_a = obs_iff;
      flush_req = 1'b0; cycle(); cnt_a += obs_iff;
      chk("no_flush_while_busy", cnt_a, 0);
      mem_busy = 1'b0; cycle();
      chk("deferred_flush", obs_iff, 1);
      cnt_a = 0;
      repeat (2) begin cycle(); cnt_a += obs_iff; end
      chk("flush_once", cnt_a, 0);

      // flush beats an active hazard
      set_id(1, 0, 0, 0, 0, 9, 1); cycle();
      set_id(1, 9, 1, 0, 0, 0, 0); cycle();
      chk("haz_before_flush", obs_pc, 1);
      flush_req = 1'b1; cycle();
      chk("flush_wins", obs_iff, 1);
      chk("flush_no_stall", obs_pc, 0);
      flush_req = 1'b0; set_id(1, 3, 1, 0, 0, 0, 0); cycle();
      chk("after_flush_run", obs_pc, 0);

      // saturation, then async reset mid-stall
      set_id(0, 0, 0, 0, 0, 0, 0);
      mem_busy = 1'b1;
      repeat (20) cycle();
      chk("count_saturated", int'(stall_count), 15);
      #1 rst = 1'b0;
      #1;
      chk("async_pc_stall", int'(pc_stall), 0);
      chk("async_exmem_stall", int'(exmem_stall), 0);
      chk("async_count", int'(stall_count), 0);
      chk("async_state", int'(ctrl_state), 0);
      cycle();
      rst = 1'b1; mem_busy = 1'b0;
      cycle();

      // pending flush is lost on reset
      mem_busy = 1'b1; flush_req = 1'b1; cycle();
      flush_req = 1'b0; mem_busy = 1'b0; rst = 1'b0; cycle();
      rst = 1'b1; cycle();
      chk("flush_lost_on_reset", obs_iff, 0);

      // dependency after reset
      set_id(1, 0, 0, 0, 0, 12, 1); cycle();
      set_id(1, 12, 1, 12, 1, 0, 0);
      repeat (4) cycle();
      set_id(0, 0, 0, 0, 0, 0, 0); cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
